instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Initiator side of the instruction-memory read interface.
- Owns the program counter and drives the fetch address.
- Captures the returned 16-bit instruction into an IF/ID pipeline register for the decode stage.
- Handles stall, branch redirect with flush, and halt detection.
- The memory read is combinational: the address is presented and the data is returned in the same cycle.

Parameters:
- ADDR_WIDTH, 16, width of the PC and the fetch address.
- DATA_WIDTH, 16, instruction width.
- RESET_VECTOR, 16'h0000, PC value loaded on reset.
- NOP_OPCODE, 16'h0000, instruction inserted on flush or bubble.
- HALT_OPCODE, 16'hFFFF, instruction that stops fetching.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- imem_addr  output  ADDR_WIDTH  fetch address to instruction memory; equals the PC, driven combinationally.
- imem_instr  input  DATA_WIDTH  instruction returned by memory for imem_addr in the same cycle.
- stall  input  1  decode stage cannot accept; hold the PC and IF/ID.
- branch_taken  input  1  redirect request from a later stage.
- branch_target  input  ADDR_WIDTH  new PC when branch_taken=1.
- if_instr  output  DATA_WIDTH  IF/ID instruction register.
- if_pc  output  ADDR_WIDTH  address the if_instr was fetched from.
- if_valid  output  1  if_instr holds a real instruction, not a bubble.
- halted  output  1  fetch unit is in HALT.
- fetch_count  output  16  number of instructions captured with valid=1; saturating.

Behaviour:
- Clock and reset: one clock domain is used. Reset is asynchronous and active-high. The clock port is clk and the reset port is reset.
- Reset values: pc=RESET_VECTOR, if_instr=NOP_OPCODE, if_pc=0, if_valid=0, halted=0, fetch_count=0, state=BOOT.
- Assertion mid-operation: reset forces all of the above immediately, independent of clk.
- States:
  - BOOT: one cycle after reset deasserts. No capture, and if_valid stays 0. Always transitions to RUN.
  - RUN: normal fetch.
  - HALT: fetch frozen.
- RUN, per rising edge, in priority order:
  1. branch_taken=1: pc<=branch_target; if_instr<=NOP_OPCODE; if_valid<=0. This flushes the wrong-path instruction and applies even if stall=1.
  2. stall=1: pc, if_instr, if_pc, if_valid and fetch_count all hold.
  3. Otherwise: if_instr<=imem_instr; if_pc<=pc; if_valid<=1; pc<=pc+1; fetch_count increments.
- PC width rule: the PC increment wraps modulo 2^ADDR_WIDTH, so 16'hFFFF goes to 16'h0000 with no error.
- Halt entry: when case 3 captures imem_instr==HALT_OPCODE, the halt word is delivered to decode with if_valid=1 and counted. The same edge moves the state to HALT and sets halted<=1. The PC still advances by one on that edge.
- HALT:
  - pc holds.
  - On the first edge in HALT (when stall=0), if_valid<=0 and if_instr<=NOP_OPCODE; after that they hold.
  - stall=1 while in HALT holds the IF/ID register as it is.
  - branch_taken=1 in HALT: pc<=branch_target, halted<=0, state goes to RUN, and IF/ID is flushed as in rule 1.
- Latency: an instruction at address A appears on if_instr one edge after pc==A with no stall. Fetch throughput is one instruction per cycle.
- fetch_count: saturates at 16'hFFFF and never wraps. It does not count flushes or bubbles.
- imem_addr is always the current pc, including during BOOT and HALT. The memory uses only its lower address bits, which is transparent to this block.

Decomposition:
- Shared package fetch_pkg:
  - fetch state enum {BOOT, RUN, HALT}.
  - NOP_OPCODE and HALT_OPCODE constants, which are shared with the decoder.
  - Address and instruction width constants.
- Sub-module program_counter: holds the PC register with load (branch), hold (stall/halt) and increment, all with asynchronous reset to RESET_VECTOR.
- The FSM, the IF/ID register and fetch_count stay in instruction_fetch.

Test Plan:
- Reset then free-run:
  - Stimulus: memory holds [0]=0000, [1]=0001, [2]=0002. Release reset.
  - Required: cycle 1 is BOOT with if_valid=0. On the next three edges if_instr/if_pc go 0000/0, then 0001/1, then 0002/2, with if_valid=1 each time. fetch_count=3.
- Stall hold:
  - Stimulus: assert stall for 2 cycles while pc=5.
  - Required: imem_addr stays 5. if_instr, if_pc and fetch_count are unchanged. After release, address 5 is captured on the next edge.
- Branch beats stall:
  - Stimulus: at pc=3, assert stall=1 and branch_taken=1 with target 16'h0040.
  - Required: the next edge gives pc=0040, if_valid=0, if_instr=0000. The following edge captures mem[0x40] with if_pc=0040.
- Halt:
  - Stimulus: mem[4]=FFFF.
  - Required: FFFF is delivered with if_valid=1 and if_pc=4. halted=1 and pc=5 hold indefinitely. if_valid=0 from the next edge. fetch_count is frozen.
- Exit from halt:
  - Stimulus: while halted, pulse branch_taken with target 0.
  - Required: halted=0, pc=0, and fetch resumes from address 0.
- Wrap and async reset:
  - Stimulus: branch to FFFF and run 2 cycles.
  - Required: if_pc=FFFF, then pc=0000.
  - Stimulus: then assert reset between clock edges.
  - Required: outputs go to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: widths, special opcodes and the fetch FSM state type.
// The opcode constants are also used by the decoder.
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_WIDTH = 16;
    localparam int unsigned FETCH_DATA_WIDTH = 16;

    localparam logic [FETCH_DATA_WIDTH-1:0] FETCH_NOP  = 16'h0000;
    localparam logic [FETCH_DATA_WIDTH-1:0] FETCH_HALT = 16'hFFFF;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StHalt
    } fetch_state_e;

endpackage

// File: rtl/program_counter.sv
// Program counter register: load has priority over increment, otherwise hold.
// The increment wraps modulo 2^ADDR_WIDTH.
module program_counter
    import fetch_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH   = FETCH_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_value,
    input  logic                  incr,
    output logic [ADDR_WIDTH-1:0] pc
);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_value;
        end else if (incr) begin
            pc_d = pc_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives the PC onto a combinational instruction memory and captures the
// returned word into the IF/ID register, with stall, branch flush and halt handling.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH   = FETCH_ADDR_WIDTH,
    parameter int unsigned            DATA_WIDTH   = FETCH_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0,
    parameter logic [DATA_WIDTH-1:0]  NOP_OPCODE   = FETCH_NOP,
    parameter logic [DATA_WIDTH-1:0]  HALT_OPCODE  = FETCH_HALT
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_instr,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic                  if_valid,
    output logic                  halted,
    output logic [15:0]           fetch_count
);

    fetch_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] if_instr_q, if_instr_d;
    logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
    logic                  if_valid_q, if_valid_d;
    logic                  halted_q, halted_d;
    logic [15:0]           fetch_count_q, fetch_count_d;
    logic                  pc_load;
    logic                  pc_incr;
    logic [ADDR_WIDTH-1:0] pc;

    program_counter #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_program_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (pc_load),
        .load_value (branch_target),
        .incr       (pc_incr),
        .pc         (pc)
    );

    always_comb begin
        state_d       = state_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        if_valid_d    = if_valid_q;
        halted_d      = halted_q;
        fetch_count_d = fetch_count_q;
        pc_load       = 1'b0;
        pc_incr       = 1'b0;

        case (state_q)
            StBoot: begin
                state_d = StRun;
            end
            StRun: begin
                // A redirect flushes the wrong-path word even while decode is stalled.
                if (branch_taken) begin
                    pc_load    = 1'b1;
                    if_instr_d = NOP_OPCODE;
                    if_valid_d = 1'b0;
                end else if (!stall) begin
                    pc_incr    = 1'b1;
                    if_instr_d = imem_instr;
                    if_pc_d    = pc;
                    if_valid_d = 1'b1;
                    if (fetch_count_q != 16'hFFFF) begin
                        fetch_count_d = fetch_count_q + 16'd1;
                    end
                    if (imem_instr == HALT_OPCODE) begin
                        state_d  = StHalt;
                        halted_d = 1'b1;
                    end
                end
            end
            StHalt: begin
                if (branch_taken) begin
                    pc_load    = 1'b1;
                    if_instr_d = NOP_OPCODE;
                    if_valid_d = 1'b0;
                    halted_d   = 1'b0;
                    state_d    = StRun;
                end else if (!stall) begin
                    // The halt word has been handed over; emit bubbles from now on.
                    if_instr_d = NOP_OPCODE;
                    if_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StBoot;
            if_instr_q    <= NOP_OPCODE;
            if_pc_q       <= '0;
            if_valid_q    <= 1'b0;
            halted_q      <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            if_valid_q    <= if_valid_d;
            halted_q      <= halted_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_valid    = if_valid_q;
    assign halted      = halted_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a rule-level reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] imem_addr;
    logic [15:0] imem_instr;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        if_valid;
    logic        halted;
    logic [15:0] fetch_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] mem [256];

    instruction_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_valid      (if_valid),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    // Memory decodes only the low address byte.
    assign imem_instr = mem[imem_addr[7:0]];

    // Reference model: booting / halted flags plus the architectural values.
    logic        m_boot;
    logic        m_halt;
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_ifpc;
    logic        m_valid;
    logic [15:0] m_count;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_boot  <= 1'b1;
            m_halt  <= 1'b0;
            m_pc    <= 16'h0000;
            m_instr <= 16'h0000;
            m_ifpc  <= 16'h0000;
            m_valid <= 1'b0;
            m_count <= 16'h0000;
        end else if (m_boot) begin
            m_boot <= 1'b0;
        end else if (branch_taken) begin
            m_pc    <= branch_target;
            m_instr <= 16'h0000;
            m_valid <= 1'b0;
            m_halt  <= 1'b0;
        end else if (stall) begin
            m_pc <= m_pc;
        end else if (m_halt) begin
            m_instr <= 16'h0000;
            m_valid <= 1'b0;
        end else begin
            m_instr <= mem[m_pc[7:0]];
            m_ifpc  <= m_pc;
            m_valid <= 1'b1;
            m_pc    <= m_pc + 16'd1;
            m_count <= (m_count == 16'hFFFF) ? m_count : m_count + 16'd1;
            if (mem[m_pc[7:0]] == 16'hFFFF) m_halt <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("model imem_addr", 32'(imem_addr), 32'(m_pc));
            check("model if_instr", 32'(if_instr), 32'(m_instr));
            check("model if_pc", 32'(if_pc), 32'(m_ifpc));
            check("model if_valid", 32'(if_valid), 32'(m_valid));
            check("model halted", 32'(halted), 32'(m_halt));
            check("model fetch_count", 32'(fetch_count), 32'(m_count));
        end
    end

    task automatic expect_out(input string name, input logic [15:0] instr, input logic [15:0] ifpc,
                              input logic valid, input logic [15:0] addr, input logic hlt,
                              input logic [15:0] count);
        check({name, " if_instr"}, 32'(if_instr), 32'(instr));
        check({name, " if_pc"}, 32'(if_pc), 32'(ifpc));
        check({name, " if_valid"}, 32'(if_valid), 32'(valid));
        check({name, " imem_addr"}, 32'(imem_addr), 32'(addr));
        check({name, " halted"}, 32'(halted), 32'(hlt));
        check({name, " fetch_count"}, 32'(fetch_count), 32'(count));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = (i < 16) ? 16'(i) : (16'hA000 | 16'(i));
        end
        mem[4] = 16'hFFFF;

        #1 reset = 1'b1;
        #11 expect_out("reset", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        #1 reset = 1'b0;

        // Free run after reset: BOOT, then addresses 0,1,2.
        @(negedge clk) expect_out("boot", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        @(negedge clk) expect_out("run0", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 16'h0001);
        @(negedge clk) expect_out("run1", 16'h0001, 16'h0001, 1'b1, 16'h0002, 1'b0, 16'h0002);
        @(negedge clk) expect_out("run2", 16'h0002, 16'h0002, 1'b1, 16'h0003, 1'b0, 16'h0003);

        // Branch beats stall.
        stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0040;
        @(negedge clk) expect_out("brstall", 16'h0000, 16'h0002, 1'b0, 16'h0040, 1'b0, 16'h0003);
        stall = 1'b0; branch_taken = 1'b0;
        @(negedge clk) expect_out("after_br", 16'hA040, 16'h0040, 1'b1, 16'h0041, 1'b0, 16'h0004);

        // Stall hold at pc=5.
        branch_taken = 1'b1; branch_target = 16'h0005;
        @(negedge clk) check("to5 imem_addr", 32'(imem_addr), 32'h5);
        branch_taken = 1'b0; stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk) expect_out("stall", 16'h0000, 16'h0040, 1'b0, 16'h0005, 1'b0, 16'h0004);
        end
        stall = 1'b0;
        @(negedge clk) expect_out("unstall", 16'h0005, 16'h0005, 1'b1, 16'h0006, 1'b0, 16'h0005);

        // Halt at address 4.
        branch_taken = 1'b1; branch_target = 16'h0002;
        @(negedge clk);
        branch_taken = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk) expect_out("halt_in", 16'hFFFF, 16'h0004, 1'b1, 16'h0005, 1'b1, 16'h0008);
        stall = 1'b1;
        @(negedge clk) expect_out("halt_stall", 16'hFFFF, 16'h0004, 1'b1, 16'h0005, 1'b1, 16'h0008);
        stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk) expect_out("halted", 16'h0000, 16'h0004, 1'b0, 16'h0005, 1'b1, 16'h0008);
        end

        // Exit from halt.
        branch_taken = 1'b1; branch_target = 16'h0000;
        @(negedge clk) expect_out("unhalt", 16'h0000, 16'h0004, 1'b0, 16'h0000, 1'b0, 16'h0008);
        branch_taken = 1'b0;
        @(negedge clk) expect_out("resume", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 16'h0009);

        // Saturate fetch_count with the halt word removed.
        mem[4] = 16'h0004;
        repeat (65530) @(negedge clk);
        check("sat fetch_count", 32'(fetch_count), 32'hFFFF);
        repeat (3) @(negedge clk);
        check("sat hold fetch_count", 32'(fetch_count), 32'hFFFF);
        check("sat if_valid", 32'(if_valid), 32'h1);
        mem[4] = 16'hFFFF;

        // PC wrap at FFFF.
        branch_taken = 1'b1; branch_target = 16'hFFFF;
        @(negedge clk) check("wrap imem_addr", 32'(imem_addr), 32'hFFFF);
        branch_taken = 1'b0;
        @(negedge clk) expect_out("wrap", 16'hA0FF, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 16'hFFFF);

        // Asynchronous reset between edges.
        #2 reset = 1'b1;
        #1 expect_out("async_rst", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        @(negedge clk) reset = 1'b0;
        @(negedge clk) expect_out("reboot", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        @(negedge clk) expect_out("rerun", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
